// File: rtl/dualportram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM: zero-fill FSM
// states and the legal read-latency range.
package dualportram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/dualportram_rdpipe.sv
// Per-port read output stage: turns the registered memory word into dout with a
// one-cycle valid strobe after LATENCY cycles, holding dout between reads.
module dualportram_rdpipe
  import dualportram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic             rd_oor,
  input  logic [WIDTH-1:0] mem_q,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic v1_reg;
  logic oor1_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg   <= 1'b0;
      oor1_reg <= 1'b0;
    end else begin
      v1_reg   <= rd_en;
      oor1_reg <= rd_oor;
    end
  end

  if (LATENCY == RD_LAT_MAX) begin : g_lat2
    logic [WIDTH-1:0] dout_reg;
    logic             valid_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= v1_reg;
        if (v1_reg) dout_reg <= oor1_reg ? '0 : mem_q;
      end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
  end else begin : g_lat1
    // Memory word is already registered; only a hold copy is needed between reads.
    logic [WIDTH-1:0] hold_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) hold_reg <= '0;
      else        hold_reg <= dout;
    end

    assign dout       = v1_reg ? (oor1_reg ? '0 : mem_q) : hold_reg;
    assign dout_valid = v1_reg;
  end

endmodule

// File: rtl/dualportram_be.sv
// True dual-port RAM with byte enables, read-first behaviour and a post-reset
// zero-fill. Optional collision strobe enabled by DUALPORTRAM_BE_COLLISION_EN.
module dualportram_be
  import dualportram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int WORDS          = 1024,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               we_b,
  input  logic               oe,
  input  logic               oe_b,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH/8-1:0] be_b,
  input  logic [31:0]        address,
  input  logic [31:0]        address_b,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   din_b,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   dout_b,
  output logic               dout_valid,
  output logic               dout_valid_b,
  output logic               busy,
  output logic [31:0]        length
`ifdef DUALPORTRAM_BE_COLLISION_EN
  ,
  output logic               collision
`endif
);

  localparam int          BYTES   = WIDTH / 8;
  localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int          LAT     = rd_latency_ok(RD_LATENCY) ? RD_LATENCY : RD_LAT_MIN;
  localparam logic [31:0] WORDS_U = 32'(WORDS);

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_addr_reg, clr_addr_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      IDLE:  state_next = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      CLEAR: begin
        clr_addr_next = clr_addr_reg + AW'(1);
        if (clr_addr_reg == AW'(WORDS - 1)) begin
          state_next    = READY;
          clr_addr_next = '0;
        end
      end
      READY:   state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  logic clearing;
  assign busy     = (state_reg != READY);
  assign clearing = (state_reg == CLEAR);
  assign length   = WORDS_U;

  logic          in_a, in_b;
  logic [AW-1:0] idx_a, idx_b;
  assign in_a  = (address < WORDS_U);
  assign in_b  = (address_b < WORDS_U);
  assign idx_a = address[AW-1:0];
  assign idx_b = address_b[AW-1:0];

  // The zero-fill borrows port A's write path; user requests are blocked meanwhile.
  logic               wr_a, wr_b, rd_a, rd_b;
  logic [AW-1:0]      wa_idx;
  logic [BYTES-1:0]   wa_be;
  logic [WIDTH-1:0]   wa_din;
  assign wr_a   = clearing | (we & ~busy & in_a);
  assign wr_b   = we_b & ~busy & in_b;
  assign rd_a   = oe & ~busy;
  assign rd_b   = oe_b & ~busy;
  assign wa_idx = clearing ? clr_addr_reg : idx_a;
  assign wa_be  = clearing ? '1 : be;
  assign wa_din = clearing ? '0 : din;

  logic [WIDTH-1:0] mem_q_a, mem_q_b;

  genvar gi;
  for (gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] q_a_reg, q_b_reg;

    // Port A is applied last so it wins lanes both ports enable on one address.
    always_ff @(posedge clk) begin
      if (wr_b && be_b[gi]) lane_mem[idx_b] <= din_b[gi*8 +: 8];
      if (wr_a && wa_be[gi]) lane_mem[wa_idx] <= wa_din[gi*8 +: 8];
      if (rd_a && in_a) q_a_reg <= lane_mem[idx_a];
      if (rd_b && in_b) q_b_reg <= lane_mem[idx_b];
    end

    assign mem_q_a[gi*8 +: 8] = q_a_reg;
    assign mem_q_b[gi*8 +: 8] = q_b_reg;
  end

  dualportram_rdpipe #(.WIDTH(WIDTH), .LATENCY(LAT)) u_rdpipe_a (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_a),
    .rd_oor     (~in_a),
    .mem_q      (mem_q_a),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  dualportram_rdpipe #(.WIDTH(WIDTH), .LATENCY(LAT)) u_rdpipe_b (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_b),
    .rd_oor     (~in_b),
    .mem_q      (mem_q_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b)
  );

`ifdef DUALPORTRAM_BE_COLLISION_EN
  logic       col_now;
  logic [1:0] col_pipe_reg;
  assign col_now = ~busy & in_a & in_b & (address == address_b) &
                   (we | oe) & (we_b | oe_b) & (we | we_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) col_pipe_reg <= '0;
    else        col_pipe_reg <= {col_pipe_reg[0], col_now};
  end

  assign collision = col_pipe_reg[LAT-1];
`endif

endmodule

// File: tb/tb_dualportram_be.sv
// Scoreboard bench for dualportram_be (WORDS=16, RD_LATENCY=2): reads push the
// model's expected word and due cycle; a negedge monitor pops and compares.
module tb_dualportram_be;

  localparam int N   = 16;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we, we_b, oe, oe_b;
  logic [3:0]  be, be_b;
  logic [31:0] address, address_b, din, din_b;
  logic [31:0] dout, dout_b, length;
  logic        dout_valid, dout_valid_b, busy;
`ifdef DUALPORTRAM_BE_COLLISION_EN
  logic        collision;
`endif

  dualportram_be #(
    .WIDTH(32), .WORDS(N), .RD_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .we(we), .we_b(we_b), .oe(oe), .oe_b(oe_b),
    .be(be), .be_b(be_b),
    .address(address), .address_b(address_b),
    .din(din), .din_b(din_b),
    .dout(dout), .dout_b(dout_b),
    .dout_valid(dout_valid), .dout_valid_b(dout_valid_b),
    .busy(busy), .length(length)
`ifdef DUALPORTRAM_BE_COLLISION_EN
    , .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model [N];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: valid strobes pop the scoreboard; idle cycles must hold dout.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (dout_valid) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_a_spurious: got valid data %h required no read", dout);
        end else begin
          e = qa.pop_front();
          $display("rd A data=%h cyc=%0d", dout, cyc);
          check("rd_a_data", dout, e.data);
          check("rd_a_cycle", 32'(cyc), 32'(e.due));
        end
        last_a = dout;
      end else begin
        check("hold_a", dout, last_a);
        if (qa.size() > 0 && qa[0].due < cyc) begin
          e = qa.pop_front();
          total++; bad++;
          $display("FAIL rd_a_missing: got no valid by cyc %0d required at %0d", cyc, e.due);
        end
      end
      if (dout_valid_b) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_b_spurious: got valid data %h required no read", dout_b);
        end else begin
          e = qb.pop_front();
          $display("rd B data=%h cyc=%0d", dout_b, cyc);
          check("rd_b_data", dout_b, e.data);
          check("rd_b_cycle", 32'(cyc), 32'(e.due));
        end
        last_b = dout_b;
      end else begin
        check("hold_b", dout_b, last_b);
        if (qb.size() > 0 && qb[0].due < cyc) begin
          e = qb.pop_front();
          total++; bad++;
          $display("FAIL rd_b_missing: got no valid by cyc %0d required at %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic idle_inputs();
    we = 1'b0; oe = 1'b0; we_b = 1'b0; oe_b = 1'b0;
  endtask

  // One cycle of requests on both ports; the model resolves reads before writes.
  task automatic drive(input logic wa, input logic oa, input logic [3:0] bea,
                       input logic [31:0] aa, input logic [31:0] da,
                       input logic wb, input logic ob, input logic [3:0] beb,
                       input logic [31:0] ab, input logic [31:0] db);
    exp_t e;
    we = wa; oe = oa; be = bea; address = aa; din = da;
    we_b = wb; oe_b = ob; be_b = beb; address_b = ab; din_b = db;
    if (wa || oa || wb || ob)
      $display("txn A we=%0b oe=%0b be=%h addr=%0d din=%h | B we=%0b oe=%0b be=%h addr=%0d din=%h",
               wa, oa, bea, aa, da, wb, ob, beb, ab, db);
    if (oa) begin
      e.data = (aa < N) ? model[aa] : 32'h0;
      e.due  = cyc + LAT;
      qa.push_back(e);
    end
    if (ob) begin
      e.data = (ab < N) ? model[ab] : 32'h0;
      e.due  = cyc + LAT;
      qb.push_back(e);
    end
    if (wb && ab < N)
      for (int i = 0; i < 4; i++) if (beb[i]) model[ab][8*i +: 8] = db[8*i +: 8];
    if (wa && aa < N)
      for (int i = 0; i < 4; i++) if (bea[i]) model[aa][8*i +: 8] = da[8*i +: 8];
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  // Counts busy cycles from reset release while hammering both ports with requests.
  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      we = 1'b1; oe = 1'b1; we_b = 1'b1; oe_b = 1'b1; be = 4'hF; be_b = 4'hF;
      address = $urandom_range(0, N - 1); address_b = $urandom_range(0, N - 1);
      din = $urandom | 32'h1; din_b = $urandom | 32'h1;
      n++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, dout, 32'h0);
    check({tag, "_dout_b"}, dout_b, 32'h0);
    check({tag, "_valid"}, {31'h0, dout_valid}, 32'h0);
    check({tag, "_valid_b"}, {31'h0, dout_valid_b}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < N; a++) model[a] = 32'h0;
    for (int a = 0; a < N; a++) drive(0, 1, 4'h0, a, 0, 0, 1, 4'h0, N - 1 - a, 0);
  endtask

  initial begin
    int n;
    idle_inputs();
    be = 4'h0; be_b = 4'h0; address = '0; address_b = '0; din = '0; din_b = '0;
    assert_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("length", length, 32'(N));

    reset = 1'b1;
    measure_busy(n);
    check("busy_cycles", 32'(n), 32'd17);
    read_all_zero();

    // Partial byte update over a full word
    drive(1, 0, 4'hF, 3, 32'hDEADBEEF, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 4'h1, 3, 32'h000000AA, 0, 0, 4'h0, 0, 0);
    drive(0, 1, 4'h0, 3, 0, 0, 0, 4'h0, 0, 0);
    idle_cycles(3);

    // Same-address writes from both ports
    drive(1, 0, 4'h3, 5, 32'h11111111, 1, 0, 4'h6, 5, 32'h22222222);
    drive(0, 1, 4'h0, 5, 0, 0, 1, 4'h0, 5, 0);

    // Read-first on same-cycle writes from either port
    drive(1, 1, 4'hF, 7, 32'hCAFEF00D, 0, 1, 4'h0, 7, 0);
    drive(0, 1, 4'h0, 9, 0, 1, 0, 4'hF, 9, 32'h12345678);
    drive(0, 1, 4'h0, 7, 0, 0, 1, 4'h0, 9, 0);

    // Out-of-range accesses must not alias onto in-range words
    drive(1, 0, 4'hF, 4, 32'h44444444, 0, 0, 4'h0, 0, 0);
    drive(1, 1, 4'hF, 20, 32'hFFFFFFFF, 1, 1, 4'hF, 32'h80000004, 32'hEEEEEEEE);
    drive(0, 1, 4'h0, 4, 0, 0, 1, 4'h0, 20, 0);
    idle_cycles(2);

    for (int i = 0; i < 250; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 19), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 19), $urandom);

    // Leave a non-zero word on dout, then reset asynchronously mid-cycle
    drive(1, 0, 4'hF, 7, 32'hA5A5A5A5, 0, 0, 4'h0, 0, 0);
    drive(0, 1, 4'h0, 7, 0, 0, 1, 4'h0, 7, 0);
    idle_cycles(LAT + 2);
    #2;
    assert_reset();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("busy_mid_clear", {31'h0, busy}, 32'h1);
    #2;
    assert_reset();
    #1;
    check_reset_outputs("mid_clear_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    measure_busy(n);
    check("busy_cycles_restart", 32'(n), 32'd17);
    read_all_zero();

    idle_cycles(LAT + 3);
    check("queue_a_drained", 32'(qa.size()), 32'h0);
    check("queue_b_drained", 32'(qb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dualportram_be.md
DUALPORTRAM_BE -- requirements
Module: dualportram_be

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter WORDS, default 1024, number of memory words.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles (legal values 1 or 2).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, enables the post-reset zero-fill sequence.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have ports we / we_b, input, 1, write request for port A / B.
REQ-008 SHALL have ports oe / oe_b, input, 1, read request for port A / B.
REQ-009 SHALL have ports be / be_b, input, WIDTH/8, byte enables for port A / B writes.
REQ-010 SHALL have ports address / address_b, input, 32, word address for port A / B.
REQ-011 SHALL have ports din / din_b, input, WIDTH, write data for port A / B.
REQ-012 SHALL have ports dout / dout_b, output, WIDTH, read data for port A / B.
REQ-013 SHALL have ports dout_valid / dout_valid_b, output, 1, one-cycle strobe marking new read data.
REQ-014 SHALL have port busy, output, 1, high while the zero-fill sequence runs.
REQ-015 SHALL have port length, output, 32, constant WORDS.

Function
REQ-016 SHALL write, for each port independently, only the bytes whose be bit is 1 when we=1, busy=0 and address<WORDS.
REQ-017 SHALL present read data RD_LATENCY cycles after oe (or oe_b) is sampled high, with the matching dout_valid high for exactly that cycle.
REQ-018 SHALL hold dout / dout_b unchanged when no read completes in a cycle.
REQ-019 SHALL return read-first data: a read of an address written in the same cycle by either port returns the pre-write contents.
REQ-020 SHALL, when both ports write the same address in one cycle, store port A's bytes where both be bits are set and each port's bytes where only its own be bit is set.
REQ-021 SHALL ignore writes to address>=WORDS and return 0 with dout_valid asserted for reads of address>=WORDS.
REQ-022 SHALL implement zero-fill FSM states IDLE, CLEAR, READY: reset -> IDLE; IDLE -> CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0) on the first cycle after reset release; CLEAR writes 0 to addresses 0..WORDS-1, one per cycle, then -> READY.
REQ-023 SHALL hold busy=1 in IDLE and CLEAR, and ignore all we/oe requests while busy=1 (no write, no dout_valid).
REQ-024 SHALL restart the sequence from address 0 if reset asserts during CLEAR.

Reset
REQ-025 SHALL, while reset=0, drive dout=0, dout_b=0, dout_valid=0, dout_valid_b=0, busy=1 and clear the read pipeline; memory contents are not reset except via zero-fill.

Configuration
REQ-026 SHALL, with macro DUALPORTRAM_BE_COLLISION_EN defined, add output collision (1 bit, reset 0), high for one cycle RD_LATENCY cycles after both ports access the same in-range address in one cycle with at least one write; without the macro the port and its logic are absent.

Structure
REQ-027 SHALL place the FSM state enumeration and the RD_LATENCY legality constants in shared package dualportram_pkg.
REQ-028 SHALL implement the per-port read pipeline (latency stage plus valid strobe) as sub-module dualportram_rdpipe, instantiated twice.

Verification
REQ-029 SHALL cover: WORDS=16, CLEAR_ON_RESET=1, release reset -> busy high exactly 17 cycles (IDLE + 16 CLEAR), all reads then return 0.
REQ-030 SHALL cover: A writes 0xDEADBEEF to addr 3 with be=4'b1111, then be=4'b0001 din=0x000000AA -> read returns 0xDEADBEAA.
REQ-031 SHALL cover: RD_LATENCY=2, oe at cycle t addr 3 -> dout_valid at t+2 only, dout=stored value, dout held afterward.
REQ-032 SHALL cover: same-cycle writes to addr 5, A din=0x11111111 be=4'b0011, B din=0x22222222 be=4'b0110 -> stored 0x00221111 (prior contents 0).
REQ-033 SHALL cover: read addr 20 with WORDS=16 -> dout=0, dout_valid=1; write there leaves memory unchanged.
REQ-034 SHALL cover: reset asserted mid-CLEAR at address 8 -> outputs reset immediately; after release busy high again for 17 cycles.
